// File: rtl/decode_pkg.sv
// Shared definitions for the index decoder slice: default widths, the index
// type and the binary-to-one-hot helper.
package decode_pkg;

    localparam int unsigned IDX_W_DEF = 3;
    localparam int unsigned OUT_W_DEF = 8;

    // Widest decode the helper supports; callers truncate to their own width.
    localparam int unsigned MAX_IDX_W = 6;
    localparam int unsigned MAX_OUT_W = 64;

    typedef logic [IDX_W_DEF-1:0] idx_t;

    function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [MAX_IDX_W-1:0] idx);
        onehot_of = MAX_OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/idx_fifo.sv
// Small index FIFO with occupancy count. Pointers wrap naturally modulo DEPTH
// (power of two). With INDEX_DECODER_COALESCE_EN defined it also reports
// whether a candidate index matches any occupied entry.
module idx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
`ifdef INDEX_DECODER_COALESCE_EN
    ,
    input  logic [W-1:0]               cmp_idx,
    output logic                       hit
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;

    assign dout  = mem[rd_ptr];
    assign level = count;
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef INDEX_DECODER_COALESCE_EN
    logic [PW-1:0] offset [DEPTH];

    // Distance of each slot from the head; a slot is occupied when that
    // distance is below the current count.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset[i] = PW'(i) - rd_ptr;
        end
    end

    // Match the candidate index against every occupied slot.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, offset[i]} < count) && (mem[i] == cmp_idx)) begin
                hit = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/index_decoder_dispatch.sv
// Binary index -> registered one-hot strobe dispatcher. Indices enter over
// valid/ready, queue in idx_fifo and are presented one at a time, each held
// until acknowledged. Total capacity is DEPTH FIFO entries plus the output
// register. Optional INDEX_DECODER_COALESCE_EN drops indices already pending
// and counts them on dropped_cnt.
module index_decoder_dispatch
    import decode_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [IDX_W-1:0]           in_idx,
    output logic                       in_ready,
    input  logic                       enable,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_onehot,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH):0]     level
`ifdef INDEX_DECODER_COALESCE_EN
    ,
    output logic [7:0]                 dropped_cnt
`endif
);

    logic [IDX_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             xfer;
    logic             dup;
    logic             store;
    logic             consumed;
    logic             load_en;
    logic             bypass;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] load_idx;
    logic             out_valid_r;
    logic [OUT_W-1:0] out_onehot_r;

    // in_ready depends on state only (level != DEPTH).
    assign in_ready = !fifo_full;
    assign xfer     = in_valid && in_ready;
    assign consumed = out_valid_r && out_ack && enable;
    assign load_en  = enable && (!out_valid_r || consumed);

`ifdef INDEX_DECODER_COALESCE_EN
    logic [IDX_W-1:0] out_idx_r;
    logic             fifo_hit;

    assign dup = xfer && ((out_valid_r && (in_idx == out_idx_r)) || fifo_hit);
`else
    assign dup = 1'b0;
`endif

    // FIFO head has priority; the incoming index only bypasses into the
    // output register when the FIFO is empty.
    assign store    = xfer && !dup;
    assign pop      = load_en && !fifo_empty;
    assign bypass   = load_en && fifo_empty && store;
    assign push     = store && !bypass;
    assign load_idx = pop ? fifo_head : in_idx;

    idx_fifo #(
        .DEPTH (DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .din     (in_idx),
        .dout    (fifo_head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
`ifdef INDEX_DECODER_COALESCE_EN
        ,
        .cmp_idx (in_idx),
        .hit     (fifo_hit)
`endif
    );

    // Output register: load a new strobe, or clear after consumption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_onehot_r <= '0;
        end else if (pop || bypass) begin
            out_valid_r  <= 1'b1;
            out_onehot_r <= OUT_W'(onehot_of(MAX_IDX_W'(load_idx)));
        end else if (consumed) begin
            out_valid_r  <= 1'b0;
            out_onehot_r <= '0;
        end
    end

    // enable gates the visible outputs but leaves the register untouched.
    assign out_valid  = out_valid_r && enable;
    assign out_onehot = enable ? out_onehot_r : '0;

`ifdef INDEX_DECODER_COALESCE_EN
    // Binary copy of the presented index for duplicate detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_idx_r <= '0;
        end else if (pop || bypass) begin
            out_idx_r <= load_idx;
        end
    end

    // Saturating count of coalesced indices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_cnt <= '0;
        end else if (dup && (dropped_cnt != 8'hFF)) begin
            dropped_cnt <= dropped_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_index_decoder_dispatch.sv
// Self-checking bench for index_decoder_dispatch. A queue holds every stored
// index in order; a flag tracks whether its head sits in the output register.
module tb_index_decoder_dispatch;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [2:0] in_idx;
    logic       in_ready;
    logic       enable;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic       out_ack;
    logic [2:0] level;
`ifdef INDEX_DECODER_COALESCE_EN
    logic [7:0] dropped_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] exp_q [$];
    bit         occ;
    int         drops;

    index_decoder_dispatch #(
        .IDX_W (3),
        .OUT_W (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_idx      (in_idx),
        .in_ready    (in_ready),
        .enable      (enable),
        .out_valid   (out_valid),
        .out_onehot  (out_onehot),
        .out_ack     (out_ack),
        .level       (level)
`ifdef INDEX_DECODER_COALESCE_EN
        ,
        .dropped_cnt (dropped_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        occ   = 1'b0;
        drops = 0;
    endtask

    // One clock cycle: drive, predict, clock, compare.
    task automatic step(input logic v, input logic [2:0] idx, input logic en, input logic ack);
        int         fifo_lvl;
        bit         rdy;
        bit         xfer;
        bit         dup;
        bit         cons;
        bit         ld;
        logic [7:0] want_oh;
        in_valid = v;
        in_idx   = idx;
        enable   = en;
        out_ack  = ack;
        fifo_lvl = exp_q.size() - (occ ? 1 : 0);
        rdy      = (fifo_lvl != DEPTH);
        check("in_ready", 32'(in_ready), 32'(rdy));
        xfer = v && rdy;
        dup  = 1'b0;
`ifdef INDEX_DECODER_COALESCE_EN
        if (xfer) begin
            foreach (exp_q[k]) if (exp_q[k] == idx) dup = 1'b1;
        end
`endif
        cons = occ && ack && en;
        ld   = en && (!occ || cons);
        @(posedge clk);
        #1;
        if (cons) void'(exp_q.pop_front());
        if (xfer && !dup) exp_q.push_back(idx);
        if (dup && drops < 255) drops++;
        if (ld) occ = (exp_q.size() > 0);
        want_oh = 8'd0;
        if (en && occ) want_oh = 8'd1 << exp_q[0];
        check("level", 32'(level), 32'(exp_q.size() - (occ ? 1 : 0)));
        check("out_valid", 32'(out_valid), 32'(en && occ));
        check("out_onehot", 32'(out_onehot), 32'(want_oh));
`ifdef INDEX_DECODER_COALESCE_EN
        check("dropped_cnt", 32'(dropped_cnt), 32'(drops));
`endif
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_idx   = '0;
        enable   = 1'b1;
        out_ack  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_onehot", 32'(out_onehot), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single index, then acknowledge.
        step(1'b1, 3'd5, 1'b1, 1'b0);
        check("single_oh", 32'(out_onehot), 32'h20);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        check("single_clr", 32'(out_valid), 32'd0);

        // Fill to DEPTH+1, refused sixth push, drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 1'b1, 1'b0);
        check("fill_level", 32'(level), 32'd4);
        check("fill_ready", 32'(in_ready), 32'd0);
        step(1'b1, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b1, 1'b1);

        // Simultaneous push and pop at level 2.
        step(1'b1, 3'd1, 1'b1, 1'b0);
        step(1'b1, 3'd2, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd7, 1'b1, 1'b1);
        check("simul_level", 32'(level), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b0);

        // Enable gating with a pending strobe; input still accepted.
        step(1'b1, 3'd2, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 3'd6, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check("gate_back", 32'(out_onehot), 32'h04);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);

        // Index accepted while disabled with an empty output register.
        step(1'b1, 3'd4, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 1'b1, 1'b1);

        // Async reset mid-stream at level 3 with a pending strobe.
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i + 1), 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("amid_out_valid", 32'(out_valid), 32'd0);
        check("amid_out_onehot", 32'(out_onehot), 32'd0);
        check("amid_level", 32'(level), 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("amid_in_ready", 32'(in_ready), 32'd1);
        step(1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1);

`ifdef INDEX_DECODER_COALESCE_EN
        // Duplicates of a pending index are dropped and counted.
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b0);
        check("coal_level", 32'(level), 32'd1);
        check("coal_drop", 32'(dropped_cnt), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
